// File: rtl/reg_pipe_pkg.sv
// Shared defaults and helpers for the reg_pipe shift-register pipeline.
// Optional preset behaviour is enabled with the REG_PIPE_PRESET_EN macro.
package reg_pipe_pkg;

    localparam int       DEF_WIDTH      = 8;
    localparam int       DEF_DEPTH      = 4;
    // Preset defaults to all-ones at any width, so it is kept as a fill bit.
    localparam logic     DEF_PRESET_BIT = 1'b1;
    localparam logic [7:0] DEF_PRESET_VAL = {8{DEF_PRESET_BIT}};

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: WIDTH data bits plus a valid bit.
// Controls are already resolved for the build configuration by the parent.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{DEF_PRESET_BIT}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             preset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;

    // Stage register with priority reset > preset > clear > en > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (preset) begin
            data_r  <= PRESET_VAL;
            valid_r <= 1'b1;
        end else if (clear) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (en) begin
            data_r  <= load_data;
            valid_r <= load_valid;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
        end
    end

    assign data  = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/reg_pipe.sv
// Parameterised register pipeline with taps and a valid-stage counter.
// Define REG_PIPE_PRESET_EN to honour the preset input; otherwise it is ignored.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               DEPTH      = DEF_DEPTH,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{DEF_PRESET_BIT}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         preset,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [DEPTH*WIDTH-1:0]       taps,
    output logic [cnt_width(DEPTH)-1:0]  count
);

    localparam int CW = cnt_width(DEPTH);

    logic             preset_s;
    logic [WIDTH-1:0] data_s [DEPTH];
    logic [DEPTH-1:0] valid_s;
    logic [CW-1:0]    count_r;

`ifdef REG_PIPE_PRESET_EN
    assign preset_s = preset;
`else
    logic unused_preset_s;
    assign unused_preset_s = preset;
    assign preset_s        = 1'b0;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] load_data_s;
        logic             load_valid_s;

        if (i == 0) begin : g_head
            assign load_data_s  = d;
            assign load_valid_s = d_valid;
        end else begin : g_body
            assign load_data_s  = data_s[i-1];
            assign load_valid_s = valid_s[i-1];
        end

        reg_pipe_stage #(
            .WIDTH      (WIDTH),
            .PRESET_VAL (PRESET_VAL)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .preset     (preset_s),
            .clear      (clear),
            .en         (en),
            .load_data  (load_data_s),
            .load_valid (load_valid_s),
            .data       (data_s[i]),
            .valid      (valid_s[i])
        );

        assign taps[i*WIDTH +: WIDTH] = data_s[i];
    end

    // Occupancy tracks valid bits incrementally: one enters at the head, one leaves at the tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (preset_s) begin
            count_r <= CW'(DEPTH);
        end else if (clear) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + CW'(d_valid) - CW'(valid_s[DEPTH-1]);
        end else begin
            count_r <= count_r;
        end
    end

    assign q       = data_s[DEPTH-1];
    assign q_valid = valid_s[DEPTH-1];
    assign count   = count_r;

endmodule
